// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared widths, word type and lane-state enum for the Hack word path
package hack_pkg;

  localparam int WORD_W = 16;
  localparam int LANES  = 8;
  localparam int SEL_W  = 3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lane_st_t;

  // One-hot lane mask for a select value
  function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
    logic [LANES-1:0] m;
    m      = '0;
    m[sel] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/dmux_lane_fifo.sv
// rtl/dmux_lane_fifo.sv - two-entry per-lane word buffer
module dmux_lane_fifo
  import hack_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  word_t push_data,
  output logic  space,
  input  logic  pop,
  output word_t head,
  output logic  head_valid
);

  lane_st_t state;
  word_t    tail;
  logic     do_push;
  logic     do_pop;

  // Space and validity come from registered state only, so the producer's
  // ready never sees the consumer's ready combinationally.
  assign space      = (state != FULL);
  assign head_valid = (state != EMPTY);
  assign do_push    = push && (state != FULL);
  assign do_pop     = pop && (state != EMPTY);

  // Occupancy and storage: head is the oldest word, tail is the second word when FULL
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (do_push) begin
            head  <= push_data;
            state <= ONE;
          end
        end
        ONE: begin
          if (do_push && do_pop) begin
            head <= push_data;
          end else if (do_push) begin
            tail  <= push_data;
            state <= FULL;
          end else if (do_pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (do_pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/dmux8way16_buf.sv
// rtl/dmux8way16_buf.sv - buffered 1-to-8 demultiplexer for 16-bit words with broadcast
module dmux8way16_buf
  import hack_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WORD_W-1:0]             in_data,
  input  logic [SEL_W-1:0]              in_sel,
  input  logic                          in_bcast,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [LANES-1:0][WORD_W-1:0]  out_data,
  output logic [LANES-1:0]              out_valid,
  input  logic [LANES-1:0]              out_ready
);

  logic [LANES-1:0] space;
  logic [LANES-1:0] push_en;
  logic [LANES-1:0] push;
  logic [LANES-1:0] pop;
  logic             accept;

  // Destination lanes: the selected lane, or every lane for a broadcast
  always_comb begin
    push_en = lane_onehot(in_sel);
    if (in_bcast) begin
      push_en = '1;
    end
  end

  // Ready from registered lane space; a popping FULL lane still reports no space
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = in_bcast ? (&space) : space[in_sel];
    end
  end

  assign accept = in_valid & in_ready;
  assign push   = push_en & {LANES{accept}};
  assign pop    = out_valid & out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dmux_lane_fifo u_lane (
      .clk        (clk),
      .reset      (reset),
      .push       (push[i]),
      .push_data  (in_data),
      .space      (space[i]),
      .pop        (pop[i]),
      .head       (out_data[i]),
      .head_valid (out_valid[i])
    );
  end

endmodule

// File: tb/tb_dmux8way16_buf.sv
// tb/tb_dmux8way16_buf.sv - scoreboard bench for dmux8way16_buf
module tb_dmux8way16_buf;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic [15:0]      in_data   = '0;
  logic [2:0]       in_sel    = '0;
  logic             in_bcast  = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [7:0][15:0] out_data;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready = 8'hFF;

  dmux8way16_buf dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: each lane is an ordered list of words, capacity two
  typedef logic [15:0] wq_t [$];
  wq_t q [8];

  logic        rst_s     = 1'b1;
  logic        acc_s     = 1'b0;
  logic [7:0]  pop_s     = '0;
  logic [15:0] acc_data  = '0;
  logic [2:0]  acc_sel   = '0;
  logic        acc_bcast = 1'b0;
  logic        exp_rdy;
  logic        done      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the reference away from the active edge
  always @(negedge clk) begin
    rst_s = reset;
    acc_s = 1'b0;
    pop_s = '0;
    if (!reset) begin
      if (in_valid) begin
        if (in_bcast) begin
          exp_rdy = 1'b1;
          for (int i = 0; i < 8; i++) if (q[i].size() >= 2) exp_rdy = 1'b0;
        end else begin
          exp_rdy = (q[in_sel].size() < 2);
        end
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        acc_s     = in_ready;
        acc_data  = in_data;
        acc_sel   = in_sel;
        acc_bcast = in_bcast;
      end
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("out_valid[%0d]", i), {31'b0, out_valid[i]}, {31'b0, q[i].size() != 0});
        if (out_valid[i] && q[i].size() != 0) begin
          chk($sformatf("head[%0d]", i), {16'b0, out_data[i]}, {16'b0, q[i][0]});
          pop_s[i] = out_ready[i];
        end
      end
    end
  end

  // Reference update at the edge from what the monitor captured
  always @(posedge clk) begin
    if (rst_s) begin
      for (int i = 0; i < 8; i++) q[i].delete();
    end else begin
      for (int i = 0; i < 8; i++) if (pop_s[i]) void'(q[i].pop_front());
      if (acc_s) begin
        for (int i = 0; i < 8; i++) if (acc_bcast || acc_sel == 3'(i)) q[i].push_back(acc_data);
      end
    end
  end

  // Present one word and hold it until accepted; cyc = edges taken
  task automatic send(input logic [15:0] d, input logic [2:0] s, input logic b, output int cyc);
    cyc      = 0;
    in_data  = d;
    in_sel   = s;
    in_bcast = b;
    in_valid = 1'b1;
    do begin
      @(posedge clk);
      cyc++;
    end while (!acc_s && cyc < 50);
    if (!acc_s) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: word %0h not accepted within %0d cycles", d, cyc);
    end
    #1;
    in_valid = 1'b0;
    in_bcast = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    logic [31:0] r;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_out_valid", {24'b0, out_valid}, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_out_data[%0d]", i), {16'b0, out_data[i]}, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;

    // Unicast fill, no stalls
    out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      send(16'(i + 1), 3'(i), 1'b0, c);
      chk($sformatf("fill_no_stall[%0d]", i), c, 1);
    end

    // Backpressure on lane 3
    out_ready = 8'hF7;
    send(16'hA000, 3'd3, 1'b0, c); chk("bp_first", c, 1);
    send(16'hA001, 3'd3, 1'b0, c); chk("bp_second", c, 1);
    fork
      send(16'hA002, 3'd3, 1'b0, c);
      begin
        repeat (3) begin @(negedge clk); chk("bp_stalled", {31'b0, in_ready}, 0); end
        @(posedge clk); #1 out_ready[3] = 1'b1;
      end
    join
    chk("bp_third_wait", c, 5);
    send(16'h5555, 3'd5, 1'b0, c); chk("bp_lane5_after", c, 1);

    // Broadcast blocked by FULL lane 6
    out_ready = 8'hBF;
    send(16'h6001, 3'd6, 1'b0, c);
    send(16'h6002, 3'd6, 1'b0, c);
    fork
      send(16'hBEEF, 3'd0, 1'b1, c);
      begin
        repeat (3) begin @(negedge clk); chk("bcast_stalled", {31'b0, in_ready}, 0); end
        @(posedge clk); #1 out_ready[6] = 1'b1;
      end
    join
    chk("bcast_wait", c, 5);
    repeat (6) @(posedge clk);
    #1;

    // Simultaneous push and pop on lane 2 in ONE
    out_ready = 8'hFB;
    send(16'h1111, 3'd2, 1'b0, c);
    out_ready[2] = 1'b1;
    send(16'h2222, 3'd2, 1'b0, c);
    chk("pp_no_stall", c, 1);
    @(negedge clk);
    chk("pp_valid", {31'b0, out_valid[2]}, 1);
    chk("pp_head", {16'b0, out_data[2]}, 32'h2222);
    @(posedge clk); #1;

    // FULL-lane bubble on lane 1
    out_ready = 8'hFD;
    send(16'h1A01, 3'd1, 1'b0, c);
    send(16'h1A02, 3'd1, 1'b0, c);
    out_ready[1] = 1'b1;
    in_data  = 16'h1A03;
    in_sel   = 3'd1;
    in_valid = 1'b1;
    @(negedge clk); chk("bubble_low", {31'b0, in_ready}, 0);
    @(negedge clk); chk("bubble_high", {31'b0, in_ready}, 1);
    @(posedge clk); #1 in_valid = 1'b0;

    // Randomized traffic with random consumer stalls
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 120; k++) begin
          r = $urandom;
          send(r[15:0], r[18:16], r[31:28] == 4'd0, c);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1 out_ready = 8'($urandom);
        end
      end
    join
    out_ready = 8'hFF;
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-stream with lanes 0 and 4 FULL
    out_ready = 8'h00;
    send(16'h0A01, 3'd0, 1'b0, c);
    send(16'h0A02, 3'd0, 1'b0, c);
    send(16'h4A01, 3'd4, 1'b0, c);
    send(16'h4A02, 3'd4, 1'b0, c);
    reset = 1'b1;
    @(negedge clk); chk("mid_rst_ready", {31'b0, in_ready}, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", {24'b0, out_valid}, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("mid_rst_out_data[%0d]", i), {16'b0, out_data[i]}, 0);
    chk("mid_rst_ready_after", {31'b0, in_ready}, 1);

    // Final drain
    out_ready = 8'hFF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_empty", {24'b0, out_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
